run_sequencer: RTL and testbench



---
 rtl/run_seq_pkg.sv | 21 ++
 rtl/phase_timer.sv | 29 ++
 rtl/run_sequencer.sv | 136 +++++++++++++
 tb/tb_run_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and constants for the host-side run sequencer.
// The cycle-count width is shared with the processor's internal cycle counter.
package run_seq_pkg;

    localparam int unsigned RST_CYC_DEF   = 2;
    localparam int unsigned START_CYC_DEF = 1;
    localparam int unsigned TIMEOUT_DEF   = 4096;
    localparam int unsigned BLANK_CYC_DEF = 1;

    localparam int unsigned CYC_W   = 16;
    localparam int unsigned PHASE_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } run_state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the RST, START and Ack-blanking phases.
// The expiry flag is high while the count sits at zero.
module phase_timer
    import run_seq_pkg::*;
#(
    parameter int unsigned W = PHASE_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic [W-1:0] loadVal_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/run_sequencer.sv
// Launches one processor program run: core reset, Start pulse, then waits for Ack
// with a cycle budget, and reports completion, timeout and measured cycle count.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned RST_CYC   = RST_CYC_DEF,
    parameter int unsigned START_CYC = START_CYC_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
    parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    input  logic             DutAck,
    output logic             DutReset,
    output logic             DutStart,
    output logic             Busy,
    output logic             Done,
    output logic             TimedOut,
    output logic [CYC_W-1:0] CycleCt,
    output logic [7:0]       RunCount
);

    // Timer is loaded with length-1 so that expiry marks the last cycle of a phase.
    localparam logic [PHASE_W-1:0] RST_LOAD   = PHASE_W'(RST_CYC - 1);
    localparam logic [PHASE_W-1:0] START_LOAD = PHASE_W'(START_CYC - 1);
    localparam logic [PHASE_W-1:0] BLANK_LOAD = PHASE_W'(BLANK_CYC);
    localparam logic [CYC_W-1:0]   TIMEOUT_V  = CYC_W'(TIMEOUT);

    run_state_e         state_q, state_d;
    logic [CYC_W-1:0]   cycleCt_q, cycleCt_d;
    logic [CYC_W-1:0]   cycNext;
    logic [7:0]         runCount_q, runCount_d;
    logic               timedOut_q, timedOut_d;
    logic               dutReset_q, dutStart_q, busy_q, done_q;
    logic               timerLoad;
    logic [PHASE_W-1:0] timerVal;
    logic               phaseDone;
    logic               ackOk;

    phase_timer #(
        .W(PHASE_W)
    ) uPhaseTimer (
        .Clk       (Clk),
        .Reset     (Reset),
        .load_i    (timerLoad),
        .loadVal_i (timerVal),
        .expired_o (phaseDone)
    );

    assign cycNext = cycleCt_q + {{(CYC_W-1){1'b0}}, 1'b1};
    assign ackOk   = phaseDone & DutAck;

    always_comb begin
        state_d    = state_q;
        cycleCt_d  = cycleCt_q;
        runCount_d = runCount_q;
        timedOut_d = timedOut_q;
        timerLoad  = 1'b0;
        timerVal   = '0;
        unique case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d    = RST;
                    timerLoad  = 1'b1;
                    timerVal   = RST_LOAD;
                    cycleCt_d  = '0;
                    timedOut_d = 1'b0;
                end
            end
            RST: begin
                if (phaseDone) begin
                    state_d   = START;
                    timerLoad = 1'b1;
                    timerVal  = START_LOAD;
                end
            end
            START: begin
                if (phaseDone) begin
                    state_d   = RUN;
                    timerLoad = 1'b1;
                    timerVal  = BLANK_LOAD;
                end
            end
            RUN: begin
                cycleCt_d = cycNext;
                // An accepted Ack takes priority over a timeout on the same cycle.
                if (ackOk) begin
                    state_d    = DONE;
                    runCount_d = runCount_q + 8'd1;
                end else if (cycNext == TIMEOUT_V) begin
                    state_d    = DONE;
                    timedOut_d = 1'b1;
                    runCount_d = runCount_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cycleCt_q  <= '0;
            runCount_q <= '0;
            timedOut_q <= 1'b0;
            dutReset_q <= 1'b0;
            dutStart_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycleCt_q  <= cycleCt_d;
            runCount_q <= runCount_d;
            timedOut_q <= timedOut_d;
            dutReset_q <= (state_d == RST);
            dutStart_q <= (state_d == START);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign DutReset = dutReset_q;
    assign DutStart = dutStart_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign TimedOut = timedOut_q;
    assign CycleCt  = cycleCt_q;
    assign RunCount = runCount_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: run-level reference model predicts when
// each run ends, its cycle count, timeout status and the running completion count.
module tb_run_sequencer;

    localparam int RST_P   = 2;
    localparam int START_P = 1;
    localparam int TMO_P   = 20;
    localparam int BLANK_P = 1;
    localparam int PRE_P   = RST_P + START_P;

    logic        Clk;
    logic        Reset;
    logic        Go;
    logic        DutAck;
    logic        DutReset;
    logic        DutStart;
    logic        Busy;
    logic        Done;
    logic        TimedOut;
    logic [15:0] CycleCt;
    logic [7:0]  RunCount;

    int vectors     = 0;
    int miscompares = 0;
    int expRuns     = 0;

    run_sequencer #(
        .RST_CYC   (RST_P),
        .START_CYC (START_P),
        .TIMEOUT   (TMO_P),
        .BLANK_CYC (BLANK_P)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Go       (Go),
        .DutAck   (DutAck),
        .DutReset (DutReset),
        .DutStart (DutStart),
        .Busy     (Busy),
        .Done     (Done),
        .TimedOut (TimedOut),
        .CycleCt  (CycleCt),
        .RunCount (RunCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ack level the bench drives during RUN cycle n (n<=0 is before RUN).
    function automatic logic ackAt(input int n, input int from, input bit noise);
        return (noise && n <= BLANK_P) || (from != 0 && n >= from);
    endfunction

    // One launch; entered and left on a negedge. abortN>0 resets the block mid-RUN.
    task automatic applyStimulus(input int ackFrom, input bit noise, input bit keepGo,
                                 input bit goNoise, input int abortN);
        int t, n, rstHigh, startHigh, expEnd;
        bit expTo, seen;
        expEnd = TMO_P;
        expTo  = 1'b1;
        for (int k = BLANK_P + 1; k <= TMO_P; k++) begin
            if (expTo && ackAt(k, ackFrom, noise)) begin
                expEnd = k;
                expTo  = 1'b0;
            end
        end
        Go        = 1'b1;
        DutAck    = ackAt(-PRE_P, ackFrom, noise);
        t         = 0;
        rstHigh   = 0;
        startHigh = 0;
        seen      = 1'b0;
        while (!seen && t < 60) begin
            @(posedge Clk);
            @(negedge Clk);
            t++;
            n = t - PRE_P;
            if (DutReset) rstHigh++;
            if (DutStart) startHigh++;
            if (t == 1) begin
                checkOutput("launchBusy", 32'(Busy), 1);
                checkOutput("launchDutReset", 32'(DutReset), 1);
                checkOutput("launchCycleCt", 32'(CycleCt), 0);
                checkOutput("launchTimedOut", 32'(TimedOut), 0);
            end
            if (Done) begin
                seen = 1'b1;
            end else begin
                if (n >= 1) checkOutput("runCycleCt", 32'(CycleCt), n - 1);
                if (abortN > 0 && n == abortN + 1) begin
                    Reset = 1'b1;
                    Go    = 1'($urandom_range(0, 1));
                    @(posedge Clk);
                    @(negedge Clk);
                    expRuns = 0;
                    checkOutput("abortBusy", 32'(Busy), 0);
                    checkOutput("abortCycleCt", 32'(CycleCt), 0);
                    checkOutput("abortRunCount", 32'(RunCount), 0);
                    checkOutput("abortDutReset", 32'(DutReset), 0);
                    checkOutput("abortDutStart", 32'(DutStart), 0);
                    checkOutput("abortDone", 32'(Done), 0);
                    Reset  = 1'b0;
                    Go     = 1'b0;
                    DutAck = 1'b0;
                    repeat (3) begin
                        @(posedge Clk);
                        @(negedge Clk);
                        checkOutput("abortStayIdle", 32'(Busy), 0);
                    end
                    return;
                end
                Go     = keepGo ? 1'b1 : (goNoise ? 1'($urandom_range(0, 1)) : 1'b0);
                DutAck = ackAt(n, ackFrom, noise);
            end
        end
        checkOutput("doneSeen", 32'(seen), 1);
        if (seen) begin
            expRuns = (expRuns + 1) % 256;
            checkOutput("doneTime", t, PRE_P + expEnd + 1);
            checkOutput("doneCycleCt", 32'(CycleCt), expEnd);
            checkOutput("doneTimedOut", 32'(TimedOut), 32'(expTo));
            checkOutput("doneRunCount", 32'(RunCount), expRuns);
            checkOutput("doneBusy", 32'(Busy), 1);
            checkOutput("rstCycles", rstHigh, RST_P);
            checkOutput("startCycles", startHigh, START_P);
            Go     = keepGo;
            DutAck = 1'b0;
            @(posedge Clk);
            @(negedge Clk);
            checkOutput("idleBusy", 32'(Busy), 0);
            checkOutput("idleDone", 32'(Done), 0);
            checkOutput("idleCycleCtHold", 32'(CycleCt), expEnd);
            checkOutput("idleTimedOutHold", 32'(TimedOut), 32'(expTo));
        end
    endtask

    initial begin
        Reset  = 1'b1;
        Go     = 1'b0;
        DutAck = 1'b0;
        repeat (2) @(negedge Clk);
        checkOutput("rstBusy", 32'(Busy), 0);
        checkOutput("rstDone", 32'(Done), 0);
        checkOutput("rstDutReset", 32'(DutReset), 0);
        checkOutput("rstDutStart", 32'(DutStart), 0);
        checkOutput("rstTimedOut", 32'(TimedOut), 0);
        checkOutput("rstCycleCt", 32'(CycleCt), 0);
        checkOutput("rstRunCount", 32'(RunCount), 0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("idleNoGo", 32'(Busy), 0);

        applyStimulus(11, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(6, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(3, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(4, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(5, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 5);
        applyStimulus(20, 1'b0, 1'b0, 1'b0, 0);
        applyStimulus(21, 1'b1, 1'b0, 1'b1, 0);

        for (int r = 0; r < 10; r++) begin
            applyStimulus(int'($urandom_range(0, 22)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
